// File: rtl/pc_pkg.sv
// ============================================================================
//  Module   : pc_pkg
//  Brief    : Shared types, default constants and helpers for pc_gen.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  // Fetch-sequencer states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int unsigned DEF_XLEN         = 32;
  localparam int unsigned DEF_INC          = 4;
  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;

  // Mask that clears the low log2(inc) bits; inc is a power of two.
  function automatic logic [63:0] inc_align_mask(input logic [63:0] inc);
    return ~(inc - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_en_reg.sv
// ============================================================================
//  Module   : pc_en_reg
//  Brief    : Parametrised-width register with enable and synchronous
//             active-low reset to a parameter value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_en_reg #(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; reset value wins on any edge with reset low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
//  Module   : pc_gen
//  Brief    : Fetch-stage program-counter generator with valid/ready
//             handshake, stall, redirect, trap entry, halt and a wrapping
//             accepted-fetch counter.
//             Optional macro PC_ALIGN_CHECK_EN: reject redirect targets that
//             are not INC-aligned and pulse misalign_err for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       XLEN         = DEF_XLEN,
  parameter int unsigned       INC          = DEF_INC,
  parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned       CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misalign_err
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(inc_align_mask(64'(INC)));
  localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

  pc_state_e       state, state_n;
  logic            pc_valid_n;
  logic            pc_en;
  logic [XLEN-1:0] pc_n;
  logic            accept;
  logic            advance;
  logic            redirect_ok;
  logic            misalign_hit;
  logic            misalign_n;

  assign accept      = pc_valid & fetch_ready;
  assign advance     = accept & ~stall;
  assign pc_plus_inc = pc + INC_X;

`ifdef PC_ALIGN_CHECK_EN
  assign misalign_hit = redirect_valid & ((redirect_target & ~ALIGN_MASK) != '0);
  assign redirect_ok  = redirect_valid & ~misalign_hit;
`else
  assign misalign_hit = 1'b0;
  assign redirect_ok  = redirect_valid;
`endif

  // Next-pc priority mux and FSM next-state; trap beats redirect beats halt.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pc_en      = 1'b0;
    pc_valid_n = pc_valid;
    misalign_n = 1'b0;
    unique case (state)
      BOOT: begin
        state_n    = RUN;
        pc_valid_n = 1'b1;
      end
      RUN: begin
        if (trap_valid) begin
          pc_n  = trap_target & ALIGN_MASK;
          pc_en = 1'b1;
        end else if (redirect_ok) begin
          pc_n  = redirect_target;
          pc_en = 1'b1;
        end else begin
          misalign_n = misalign_hit;
          if (halt) begin
            state_n    = HALT;
            pc_valid_n = 1'b0;
          end else if (advance) begin
            pc_n  = pc + INC_X;
            pc_en = 1'b1;
          end
        end
      end
      HALT: begin
        if (trap_valid) begin
          pc_n       = trap_target & ALIGN_MASK;
          pc_en      = 1'b1;
          state_n    = RUN;
          pc_valid_n = 1'b1;
        end else if (redirect_ok) begin
          pc_n       = redirect_target;
          pc_en      = 1'b1;
          state_n    = RUN;
          pc_valid_n = 1'b1;
        end else begin
          misalign_n = misalign_hit;
        end
      end
      default: begin
        state_n    = BOOT;
        pc_valid_n = 1'b0;
      end
    endcase
  end

  // State and request-valid registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= BOOT;
      pc_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc_valid <= pc_valid_n;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // One-cycle error pulse for each rejected misaligned redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign_n;
    end
  end
`else
  assign misalign_err = 1'b0;
  logic unused_misalign;
  assign unused_misalign = misalign_n;
`endif

  pc_en_reg #(
    .W       (XLEN),
    .RST_VAL (RESET_VECTOR)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_n),
    .q     (pc)
  );

  // Every accepted request counts, even while stalled.
  pc_en_reg #(
    .W       (CNT_W),
    .RST_VAL ('0)
  ) u_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (fetch_count + CNT_W'(1)),
    .q     (fetch_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
//  Module   : tb_pc_gen
//  Brief    : Scoreboard testbench for pc_gen with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

  localparam int unsigned CW = 6;

  typedef struct {
    logic [31:0]   pc;
    logic          v;
    logic [CW-1:0] cnt;
    logic          mis;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, halt, redirect_valid, trap_valid, fetch_ready;
  logic [31:0]   redirect_target, trap_target;
  logic [31:0]   pc, pc_plus_inc;
  logic          pc_valid, misalign_err;
  logic [CW-1:0] fetch_count;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN         (32),
    .INC          (4),
    .RESET_VECTOR (32'h0),
    .CNT_W        (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .fetch_ready     (fetch_ready),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .pc_plus_inc     (pc_plus_inc),
    .fetch_count     (fetch_count),
    .misalign_err    (misalign_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its result.
  task automatic step(input logic rst_n, input logic st, input logic hl,
                      input logic rv, input logic [31:0] rt,
                      input logic tv, input logic [31:0] tt, input logic fr,
                      input logic [31:0] epc, input logic ev,
                      input logic [CW-1:0] ec, input logic em);
    exp_t e;
    @(negedge clk);
    reset           = rst_n;
    stall           = st;
    halt            = hl;
    redirect_valid  = rv;
    redirect_target = rt;
    trap_valid      = tv;
    trap_target     = tt;
    fetch_ready     = fr;
    e.pc = epc; e.v = ev; e.cnt = ec; e.mis = em;
    q.push_back(e);
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc",           pc,                   e.pc);
      chk("pc_valid",     32'(pc_valid),        32'(e.v));
      chk("fetch_count",  32'(fetch_count),     32'(e.cnt));
      chk("misalign_err", 32'(misalign_err),    32'(e.mis));
      chk("pc_plus_inc",  pc_plus_inc,          e.pc + 32'd4);
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_PC   = 32'h24;
  localparam logic        MIS_ERR  = 1'b1;
  localparam logic [31:0] LOOP_PC0 = 32'h28;
`else
  localparam logic [31:0] MIS_PC   = 32'h102;
  localparam logic        MIS_ERR  = 1'b0;
  localparam logic [31:0] LOOP_PC0 = 32'h106;
`endif

  initial begin
    reset = 1'b0; stall = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; trap_valid = 1'b0; trap_target = '0; fetch_ready = 1'b0;

    //   rst st hl rv rt            tv tt            fr  pc            v  cnt  mis
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0,   0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0,   0);
    // Boot then sequential fetch
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 1,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        1, 2,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        1, 3,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       1, 4,   0);
    // Stall three cycles at 0x10: pc holds, count keeps rising
    step(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       1, 5,   0);
    step(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       1, 6,   0);
    step(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       1, 7,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       1, 8,   0);
    // Trap and redirect together with fetch_ready low: aligned trap wins
    step(1, 0, 0, 1, 32'h100,      1, 32'h203,      0, 32'h200,      1, 8,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204,      1, 9,   0);
    // Reach 0x40, then halt there
    step(1, 0, 0, 1, 32'h3C,       0, 32'h0,        1, 32'h3C,       1, 10,  0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       1, 11,  0);
    step(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, 12,  0);
    step(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, 12,  0);
    step(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, 12,  0);
    // Redirect out of HALT
    step(1, 0, 0, 1, 32'h80,       0, 32'h0,        0, 32'h80,       1, 12,  0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h84,       1, 13,  0);
    // PC wrap at top of address space
    step(1, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 14,  0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 15,  0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 16,  0);
    // Misaligned redirect at 0x20 with advance active
    step(1, 0, 0, 1, 32'h20,       0, 32'h0,        1, 32'h20,       1, 17,  0);
    step(1, 0, 0, 1, 32'h102,      0, 32'h0,        1, MIS_PC,       1, 18,  MIS_ERR);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, MIS_PC + 32'h4, 1, 19, 0);
    // Long sequential run: counter wraps past 2^CW - 1
    for (int i = 1; i <= 50; i++) begin
      step(1, 0, 0, 0, 32'h0, 0, 32'h0, 1, LOOP_PC0 + 32'(4 * i), 1, CW'(19 + i), 0);
    end
    // Halt and redirect together: redirect wins, stays in RUN
    step(1, 0, 1, 1, 32'h300,      0, 32'h0,        1, 32'h300,      1, 6,   0);
    step(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h300,      0, 6,   0);
    // Trap out of HALT
    step(1, 0, 0, 0, 32'h0,        1, 32'h404,      0, 32'h404,      1, 6,   0);
    // Mid-stream reset drops the request, then boot again
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0,   0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 1,   0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
